// File: rtl/rgbw_wrd2sout_if.sv
// FIFO-side bundle for rgbw_wrd2sout: head word and sideband, empty flag and pop strobe, plus the
// serial line and status outputs. The slave modport is the transmitter, the master modport is the
// environment (FIFO and pin).
interface rgbw_wrd2sout_if;
    logic [31:0] in_word;           // FIFO head: [31:24]=G [23:16]=R [15:8]=B [7:0]=W
    logic        in_word_is_reset;  // FIFO head sideband: emit a stream reset instead of a word
    logic        in_fifo_empty;     // FIFO empty flag
    logic        out_rd_strobe;     // one-clock pop pulse
    logic        out_dout;          // serial LED data line
    logic        out_busy;          // transmitter not idle
    logic        out_underrun;      // sticky: FIFO ran dry at a word boundary mid-frame

    modport slave (
        input  in_word, in_word_is_reset, in_fifo_empty,
        output out_rd_strobe, out_dout, out_busy, out_underrun
    );

    modport master (
        output in_word, in_word_is_reset, in_fifo_empty,
        input  out_rd_strobe, out_dout, out_busy, out_underrun
    );
endinterface

// File: rtl/rgbw_wrd2sout.sv
// Pixel word to WS2812b/SK6812 NRZ serialiser: pops FWFT FIFO words (MSB first) and drives the LED line.
// Latency: line rises 2 clocks after the FIFO turns non-empty while idle; word-boundary bit is TBIT_CYC+2.
// Backpressure: pops only when in_fifo_empty=0 at a word boundary; a dry FIFO mid-frame sets out_underrun.
// Ports: clk, rst_n (async active-low), bus (rgbw_wrd2sout_if.slave: FIFO head/empty/pop, dout/busy/underrun).
// Build option: define RGBW_TX_WHITE_EN for 32-bit GRBW words (SK6812); otherwise 24-bit GRB (WS2812b).
module rgbw_wrd2sout #(
    parameter int T0H_CYC    = 38,
    parameter int T1H_CYC    = 77,
    parameter int TBIT_CYC   = 120,
    parameter int TRESET_CYC = 7680,
    parameter int CNT_W      = 13
) (
    input  logic           clk,
    input  logic           rst_n,
    rgbw_wrd2sout_if.slave bus
);

`ifdef RGBW_TX_WHITE_EN
    localparam logic [4:0] LAST_IDX = 5'd0;
`else
    // W byte sits in in_word[7:0]; stopping at index 8 leaves it unsent.
    localparam logic [4:0] LAST_IDX = 5'd8;
`endif

    // Counter end values: a phase lasting N clocks ends when the counter shows N-1.
    localparam logic [CNT_W-1:0] T0H_END  = CNT_W'(T0H_CYC - 1);
    localparam logic [CNT_W-1:0] T1H_END  = CNT_W'(T1H_CYC - 1);
    localparam logic [CNT_W-1:0] LOW0_END = CNT_W'(TBIT_CYC - T0H_CYC - 1);
    localparam logic [CNT_W-1:0] LOW1_END = CNT_W'(TBIT_CYC - T1H_CYC - 1);
    localparam logic [CNT_W-1:0] RST_END  = CNT_W'(TRESET_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, RST} state_t;

    state_t           state;
    logic [31:0]      shreg;
    logic             kind_rst;
    logic [4:0]       bit_idx;
    logic [CNT_W-1:0] cnt;
    logic             in_frame;

    logic             last_bit;
    logic [CNT_W-1:0] high_end;
    logic [CNT_W-1:0] low_end;

    assign last_bit = (bit_idx == LAST_IDX);
    assign high_end = shreg[31] ? T1H_END : T0H_END;
    // The last bit of a word holds LOW one extra clock: that clock is the FIFO decision slot,
    // mirroring the idle sampling clock so both paths take IDLE/decide + LOAD before the next high.
    assign low_end  = (shreg[31] ? LOW1_END : LOW0_END) + (last_bit ? CNT_ONE : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            shreg             <= '0;
            kind_rst          <= 1'b0;
            bit_idx           <= '0;
            cnt               <= '0;
            in_frame          <= 1'b0;
            bus.out_rd_strobe <= 1'b0;
            bus.out_dout      <= 1'b0;
            bus.out_busy      <= 1'b0;
            bus.out_underrun  <= 1'b0;
        end else begin
            bus.out_rd_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    bus.out_dout <= 1'b0;
                    if (!bus.in_fifo_empty) begin
                        bus.out_rd_strobe <= 1'b1;
                        shreg             <= bus.in_word;
                        kind_rst          <= bus.in_word_is_reset;
                        cnt               <= '0;
                        bus.out_busy      <= 1'b1;
                        state             <= LOAD;
                    end else if (cnt == RST_END) begin
                        // Line has been low long enough for the LEDs to latch: frame is over.
                        in_frame <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                LOAD: begin
                    cnt <= '0;
                    if (kind_rst) begin
                        in_frame <= 1'b0;
                        state    <= RST;
                    end else begin
                        bit_idx      <= 5'd31;
                        in_frame     <= 1'b1;
                        bus.out_dout <= 1'b1;
                        state        <= HIGH;
                    end
                end
                HIGH: begin
                    if (cnt == high_end) begin
                        cnt          <= '0;
                        bus.out_dout <= 1'b0;
                        state        <= LOW;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                LOW: begin
                    if (cnt != low_end) begin
                        cnt <= cnt + CNT_ONE;
                    end else begin
                        cnt <= '0;
                        if (!last_bit) begin
                            shreg        <= {shreg[30:0], 1'b0};
                            bit_idx      <= bit_idx - 5'd1;
                            bus.out_dout <= 1'b1;
                            state        <= HIGH;
                        end else if (!bus.in_fifo_empty) begin
                            bus.out_rd_strobe <= 1'b1;
                            shreg             <= bus.in_word;
                            kind_rst          <= bus.in_word_is_reset;
                            state             <= LOAD;
                        end else begin
                            if (in_frame) begin
                                bus.out_underrun <= 1'b1;
                            end
                            bus.out_busy <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                RST: begin
                    in_frame <= 1'b0;
                    if (cnt == RST_END) begin
                        cnt          <= '0;
                        bus.out_busy <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    cnt          <= '0;
                    bus.out_dout <= 1'b0;
                    bus.out_busy <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgbw_wrd2sout.sv
// Bench for rgbw_wrd2sout: a FIFO queue feeds the DUT, a timeline model derives every cycle's
// expected outputs from each word's start clock, and pulse logs are pinned with literal values.
module tb_rgbw_wrd2sout;
    localparam int T0H  = 38;
    localparam int T1H  = 77;
    localparam int TBIT = 120;
    localparam int TRST = 7680;
`ifdef RGBW_TX_WHITE_EN
    localparam int NB = 32;
`else
    localparam int NB = 24;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rgbw_wrd2sout_if bus ();

    rgbw_wrd2sout #(
        .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .TRESET_CYC(TRST), .CNT_W(13)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] word;
        logic        is_rst;
    } ent_t;

    ent_t fq[$];   // FIFO contents as the DUT sees them
    ent_t mq[$];   // model's own copy of everything pushed

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit in_rst = 1'b1;

    // Model: the word in flight and when it started / when the transmitter is free again.
    bit   m_act = 1'b0;
    int   m_s   = 0;
    int   m_end = 0;
    ent_t m_cur;
    bit   m_und = 1'b0;
    bit   e_dout, e_busy, e_stb;

    // Observed-waveform logs.
    int rises[$];
    int widths[$];
    int stb_cnt   = 0;
    bit prev_dout = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.in_fifo_empty    = (fq.size() == 0);
        bus.in_word          = (fq.size() > 0) ? fq[0].word : 32'h0;
        bus.in_word_is_reset = (fq.size() > 0) ? fq[0].is_rst : 1'b0;
    endtask

    task automatic push(input logic [31:0] w, input logic r);
        ent_t e;
        e.word   = w;
        e.is_rst = r;
        fq.push_back(e);
        mq.push_back(e);
        drive_fifo();
    endtask

    // Expected outputs just after clock edge 'cyc'. A data word sampled at edge s loads at s,
    // bit b is high from s+1+b*TBIT for its high time, and the next word may be taken at
    // s+NB*TBIT+2. A stream reset is busy for TRST clocks after its load clock, free at s+TRST+2.
    task automatic model_edge();
        int off, b, ph;
        e_dout = 1'b0;
        e_busy = 1'b0;
        e_stb  = 1'b0;
        if (in_rst) begin
            m_act = 1'b0;
            m_und = 1'b0;
        end else begin
            if (m_act && cyc == m_end) begin
                m_act = 1'b0;
                if (!m_cur.is_rst && mq.size() == 0) m_und = 1'b1;
            end
            if (!m_act && mq.size() > 0) begin
                m_cur = mq.pop_front();
                m_act = 1'b1;
                m_s   = cyc;
                m_end = m_cur.is_rst ? cyc + TRST + 2 : cyc + NB * TBIT + 2;
            end
            if (m_act) begin
                off = cyc - m_s;
                if (off == 0) begin
                    e_stb  = 1'b1;
                    e_busy = 1'b1;
                end else if (m_cur.is_rst) begin
                    e_busy = (off <= TRST);
                end else begin
                    b      = (off - 1) / TBIT;
                    ph     = (off - 1) % TBIT;
                    e_busy = 1'b1;
                    if (b < NB) e_dout = (ph < (m_cur.word[31 - b] ? T1H : T0H));
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        model_edge();
        check("dout", bus.out_dout, e_dout);
        check("busy", bus.out_busy, e_busy);
        check("rd_strobe", bus.out_rd_strobe, e_stb);
        check("underrun", bus.out_underrun, m_und);
        if (bus.out_dout && !prev_dout) rises.push_back(cyc);
        if (!bus.out_dout && prev_dout && rises.size() > 0) widths.push_back(cyc - rises[$]);
        prev_dout = bus.out_dout;
        if (bus.out_rd_strobe) begin
            stb_cnt++;
            if (fq.size() > 0) void'(fq.pop_front());
        end
        drive_fifo();
    endtask

    task automatic tick(input int n);
        repeat (n) step();
    endtask

    task automatic run_idle();
        for (int i = 0; i < 40000 && (m_act || mq.size() > 0); i++) step();
        tick(4);
    endtask

    task automatic clear_log();
        rises.delete();
        widths.delete();
        stb_cnt = 0;
    endtask

    task automatic reset_pulse();
        rst_n  = 1'b0;
        in_rst = 1'b1;
        tick(2);
        rst_n  = 1'b1;
        in_rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p, target, first;
        int exp_a5[8];
        int exp_12[8];
        exp_a5 = '{77, 38, 77, 38, 38, 77, 38, 77};
        exp_12 = '{38, 38, 38, 77, 38, 38, 77, 38};

        drive_fifo();
        tick(3);
        check("reset_dout", bus.out_dout, 0);
        check("reset_busy", bus.out_busy, 0);
        check("reset_strobe", bus.out_rd_strobe, 0);
        check("reset_underrun", bus.out_underrun, 0);
        rst_n  = 1'b1;
        in_rst = 1'b0;
        tick(3);

        // Back-to-back all-ones then all-zeros.
        clear_log();
        push(32'hFFFF_FFFF, 1'b0);
        push(32'h0000_0000, 1'b0);
        p = cyc;
        tick(NB * TBIT + 100);
        check("b2b_no_underrun", bus.out_underrun, 0);
        run_idle();
        check("b2b_pulse_count", widths.size(), 2 * NB);
        if (widths.size() == 2 * NB) begin
            for (int i = 0; i < NB; i++) begin
                check("b2b_high_one", widths[i], 77);
                check("b2b_high_zero", widths[NB + i], 38);
            end
        end
        if (rises.size() == 2 * NB) begin
            check("b2b_first_rise", rises[0] - p, 2);
            check("b2b_bit_period", rises[1] - rises[0], 120);
            check("b2b_boundary_period", rises[NB] - rises[NB - 1], 122);
        end
        check("b2b_strobes", stb_cnt, 2);
        check("b2b_final_underrun", bus.out_underrun, 1);

        // Single 0xA5000000 after clearing the sticky flag.
        reset_pulse();
        tick(3);
        check("a5_underrun_cleared", bus.out_underrun, 0);
        clear_log();
        push(32'hA500_0000, 1'b0);
        p = cyc;
        run_idle();
        check("a5_pulse_count", widths.size(), NB);
        if (widths.size() == NB) begin
            for (int i = 0; i < NB; i++)
                check("a5_high", widths[i], (i < 8) ? exp_a5[i] : 38);
        end
        if (rises.size() == NB) begin
            check("a5_first_rise", rises[0] - p, 2);
            for (int i = 0; i < NB - 1; i++)
                check("a5_bit_period", rises[i + 1] - rises[i], 120);
        end
        check("a5_underrun", bus.out_underrun, 1);

        // Data word, stream reset, data word.
        clear_log();
        push($urandom, 1'b0);
        push($urandom, 1'b1);
        push($urandom, 1'b0);
        run_idle();
        check("rst_word_rises", rises.size(), 2 * NB);
        if (rises.size() == 2 * NB)
            check("rst_word_gap", rises[NB] - rises[NB - 1], TBIT + TRST + 4);
        check("rst_word_strobes", stb_cnt, 3);

        // Word, long dry spell, word.
        push($urandom, 1'b0);
        run_idle();
        tick(8000);
        push($urandom, 1'b0);
        run_idle();
        check("dry_underrun", bus.out_underrun, 1);

        // Random words at random spacing.
        for (int k = 0; k < 3; k++) begin
            push($urandom, 1'b0);
            tick($urandom_range(0, NB * TBIT + 300));
        end
        run_idle();

        // Async reset in the high phase of bit 12.
        clear_log();
        push($urandom, 1'b0);
        tick(2);
        target = m_s + 1 + 12 * TBIT + 10;
        for (int i = 0; i < 4000 && cyc < target; i++) step();
        #2;
        rst_n  = 1'b0;
        in_rst = 1'b1;
        #1;
        check("async_rst_dout", bus.out_dout, 0);
        check("async_rst_busy", bus.out_busy, 0);
        check("async_rst_underrun", bus.out_underrun, 0);
        push($urandom, 1'b0);
        tick(20);
        check("no_pop_in_reset", stb_cnt, 1);
        rst_n  = 1'b1;
        in_rst = 1'b0;
        p = cyc;
        rises.delete();
        run_idle();
        first = (rises.size() > 0) ? rises[0] - p : -1;
        check("post_rst_first_rise", first, 2);

        // 0x123456FF: W byte only goes out in the RGBW build.
        clear_log();
        push(32'h1234_56FF, 1'b0);
        run_idle();
        check("w_pulse_count", widths.size(), NB);
        if (widths.size() == NB) begin
            for (int i = 0; i < 8; i++) check("w_first_byte", widths[i], exp_12[i]);
`ifdef RGBW_TX_WHITE_EN
            check("w_last_bit", widths[NB - 1], 77);
`else
            check("w_last_bit", widths[NB - 1], 38);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
